// File: rtl/reg_bank_force.sv
// reg_bank_force
//   NUM_CH channels of WIDTH-bit registers sharing one clock. Each channel can
//   be overridden by a per-channel force. The forced value shows on q at once,
//   is captured into the channel on every edge while the force is held, and
//   stays in the channel after the force is released.
//   The mode input selects an addressed write, a shift chain, a rotate or a
//   synchronous clear. A saturating counter tracks accepted operations, and
//   an error pulse flags writes to channels that do not exist.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   mode     00 write/hold, 01 shift, 10 rotate, 11 sync clear
//   wr_en    write strobe (mode 00 only)
//   wr_addr  write target channel
//   din      write data (mode 00) / shift-in data (mode 01)
//   frc_en   per-channel force enable
//   frc_val  force value shared by all channels
//   q        visible channel values, channel i at [i*WIDTH +: WIDTH]
//   wr_cnt   saturating count of accepted operations
//   wr_err   one-cycle pulse after an out-of-range write
module reg_bank_force #(
    parameter int               WIDTH   = 8,
    parameter int               NUM_CH  = 4,
    parameter int               AW      = 2,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        din,
    input  logic [NUM_CH-1:0]       frc_en,
    input  logic [WIDTH-1:0]        frc_val,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [CNT_W-1:0]        wr_cnt,
    output logic                    wr_err
);

    localparam logic [1:0] MODE_WRITE  = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    // One extra bit so the range check also works when 2^AW == NUM_CH.
    localparam logic [AW:0] NUM_CH_A = (AW+1)'(NUM_CH);

    logic [WIDTH-1:0] regs     [NUM_CH];
    logic [WIDTH-1:0] regs_nxt [NUM_CH];
    logic [WIDTH-1:0] vis      [NUM_CH];
    logic             in_range;
    logic             accept;
    logic             err_nxt;

    // Shift and rotate read from the visible value, so a forced upstream
    // channel feeds its force value down the chain.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            vis[i] = frc_en[i] ? frc_val : regs[i];
        end
    end

    // Reset also masks the force on the visible output.
    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_q
            assign q[g*WIDTH +: WIDTH] = rst ? RST_VAL : vis[g];
        end
    endgenerate

    assign in_range = ({1'b0, wr_addr} < NUM_CH_A);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            regs_nxt[i] = regs[i];
        end
        accept  = 1'b0;
        err_nxt = 1'b0;

        case (mode)
            MODE_WRITE: begin
                if (wr_en) begin
                    if (in_range) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (wr_addr == AW'(i) && !frc_en[i]) begin
                                regs_nxt[i] = din;
                                accept      = 1'b1;
                            end
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            MODE_SHIFT: begin
                regs_nxt[0] = din;
                for (int i = 1; i < NUM_CH; i++) begin
                    regs_nxt[i] = vis[i-1];
                end
                accept = 1'b1;
            end
            MODE_ROTATE: begin
                regs_nxt[0] = vis[NUM_CH-1];
                for (int i = 1; i < NUM_CH; i++) begin
                    regs_nxt[i] = vis[i-1];
                end
                accept = 1'b1;
            end
            MODE_CLEAR: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    regs_nxt[i] = RST_VAL;
                end
            end
            default: ;
        endcase

        // Force wins over every mode and is what makes release hold the value.
        for (int i = 0; i < NUM_CH; i++) begin
            if (frc_en[i]) begin
                regs_nxt[i] = frc_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                regs[i] <= RST_VAL;
            end
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                regs[i] <= regs_nxt[i];
            end
            wr_err <= err_nxt;
            if (mode == MODE_CLEAR) begin
                wr_cnt <= '0;
            end else if (accept && (wr_cnt != {CNT_W{1'b1}})) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_force.sv
module tb_reg_bank_force;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;
    localparam int AW     = 3;
    localparam int CNT_W  = 3;

    logic                    clk;
    logic                    rst;
    logic [1:0]              mode;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        din;
    logic [NUM_CH-1:0]       frc_en;
    logic [WIDTH-1:0]        frc_val;
    logic [NUM_CH*WIDTH-1:0] q;
    logic [CNT_W-1:0]        wr_cnt;
    logic                    wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_force #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .AW     (AW),
        .CNT_W  (CNT_W),
        .RST_VAL(8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .din    (din),
        .frc_en (frc_en),
        .frc_val(frc_val),
        .q      (q),
        .wr_cnt (wr_cnt),
        .wr_err (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        wr_en;
        logic [2:0]  addr;
        logic [7:0]  din;
        logic [3:0]  frc_en;
        logic [7:0]  frc_val;
        logic [31:0] exp_q;
        logic [2:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input logic [3:0] fe, input logic [7:0] fv);
        mode    = m;
        wr_en   = we;
        wr_addr = a;
        din     = d;
        frc_en  = fe;
        frc_val = fv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ch3..ch0 packed in exp_q
        vecs[0]  = '{2'b00, 1'b1, 3'd2, 8'h5C, 4'b0000, 8'h00, 32'h005C00AA, 3'd1, 1'b0};
        vecs[1]  = '{2'b00, 1'b1, 3'd5, 8'hFF, 4'b0000, 8'h00, 32'h005C00AA, 3'd1, 1'b1};
        vecs[2]  = '{2'b00, 1'b1, 3'd7, 8'hFF, 4'b0000, 8'h00, 32'h005C00AA, 3'd1, 1'b1};
        vecs[3]  = '{2'b00, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00, 32'h005C00AA, 3'd1, 1'b0};
        vecs[4]  = '{2'b00, 1'b0, 3'd0, 8'h00, 4'b0010, 8'h3F, 32'h005C3FAA, 3'd1, 1'b0};
        vecs[5]  = '{2'b00, 1'b1, 3'd1, 8'h77, 4'b0010, 8'h3F, 32'h005C3FAA, 3'd1, 1'b0};
        vecs[6]  = '{2'b00, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00, 32'h005C3FAA, 3'd1, 1'b0};
        vecs[7]  = '{2'b00, 1'b1, 3'd3, 8'h04, 4'b0000, 8'h00, 32'h045C3FAA, 3'd2, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 3'd0, 8'h01, 4'b0000, 8'h00, 32'h045C3F01, 3'd3, 1'b0};
        vecs[9]  = '{2'b00, 1'b1, 3'd1, 8'h02, 4'b0000, 8'h00, 32'h045C0201, 3'd4, 1'b0};
        vecs[10] = '{2'b00, 1'b1, 3'd2, 8'h03, 4'b0000, 8'h00, 32'h04030201, 3'd5, 1'b0};
        vecs[11] = '{2'b10, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00, 32'h03020104, 3'd6, 1'b0};
        vecs[12] = '{2'b10, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00, 32'h02010403, 3'd7, 1'b0};
        vecs[13] = '{2'b10, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00, 32'h01040302, 3'd7, 1'b0};
        vecs[14] = '{2'b10, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00, 32'h04030201, 3'd7, 1'b0};
        vecs[15] = '{2'b11, 1'b0, 3'd0, 8'h00, 4'b0001, 8'h99, 32'h00000099, 3'd0, 1'b0};
        vecs[16] = '{2'b01, 1'b0, 3'd0, 8'h11, 4'b0010, 8'hEE, 32'h00EEEE11, 3'd1, 1'b0};
        vecs[17] = '{2'b01, 1'b0, 3'd0, 8'h11, 4'b0010, 8'hEE, 32'hEEEEEE11, 3'd2, 1'b0};
        vecs[18] = '{2'b01, 1'b0, 3'd0, 8'h11, 4'b0010, 8'hEE, 32'hEEEEEE11, 3'd3, 1'b0};
        vecs[19] = '{2'b01, 1'b1, 3'd5, 8'h22, 4'b0010, 8'hEE, 32'hEEEEEE22, 3'd4, 1'b0};

        // Reset with ch0 forced: reset must mask the force on q.
        rst = 1'b1;
        drive(2'b00, 1'b0, 3'd0, 8'h00, 4'b0001, 8'hAA);
        #2;
        chk("reset_q", q, 32'h00000000);
        chk("reset_cnt", 32'(wr_cnt), 32'd0);
        chk("reset_err", 32'(wr_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_reset_force_q", q, 32'h000000AA);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].wr_en, vecs[i].addr, vecs[i].din,
                  vecs[i].frc_en, vecs[i].frc_val);
            step();
            chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            chk($sformatf("vec%0d_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_err", i), 32'(wr_err), 32'(vecs[i].exp_err));
        end

        // Saturation: clear, then 9 accepted writes.
        @(negedge clk);
        drive(2'b11, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00);
        step();
        chk("clear_q", q, 32'h00000000);
        chk("clear_cnt", 32'(wr_cnt), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            drive(2'b00, 1'b1, 3'((k-1) % 4), 8'(k), 4'b0000, 8'h00);
            step();
            chk($sformatf("sat_cnt%0d", k), 32'(wr_cnt), (k > 7) ? 32'd7 : 32'(k));
        end
        chk("sat_q", q, 32'h08070609);

        // Sync clear with ch0 forced.
        @(negedge clk);
        drive(2'b11, 1'b0, 3'd0, 8'h00, 4'b0001, 8'h5A);
        step();
        chk("clear_forced_q", q, 32'h0000005A);
        chk("clear_forced_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        drive(2'b00, 1'b0, 3'd0, 8'h00, 4'b0000, 8'h00);
        step();
        chk("clear_release_hold_q", q, 32'h0000005A);

        // Force pulse between edges: visible only, not captured.
        @(negedge clk);
        frc_en  = 4'b0010;
        frc_val = 8'hC3;
        #1;
        chk("pulse_on_q", q, 32'h0000C35A);
        #1;
        frc_en = 4'b0000;
        #1;
        chk("pulse_off_q", q, 32'h0000005A);
        step();
        chk("pulse_after_edge_q", q, 32'h0000005A);

        @(negedge clk);
        drive(2'b00, 1'b1, 3'd2, 8'h33, 4'b0000, 8'h00);
        step();
        chk("pre_rst_cnt", 32'(wr_cnt), 32'd1);

        // Mid-cycle async reset with ch0 forced.
        #1;
        drive(2'b00, 1'b0, 3'd0, 8'h00, 4'b0001, 8'hAA);
        rst = 1'b1;
        #1;
        chk("async_rst_q", q, 32'h00000000);
        chk("async_rst_cnt", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_release_force_q", q, 32'h000000AA);
        @(negedge clk);
        frc_en = 4'b0000;
        #1;
        chk("rst_release_hold_q", q, 32'h000000AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
